// File: rtl/joy_conditioner_if.sv
// Joystick bundle between the serial joystick decoder and the zxuno core.
// Carries the raw active-low lines of both joysticks and the autofire
// enables into the conditioner, and the conditioned active-low lines out.
// The master drives the raw lines; the slave is the conditioner.
interface joy_conditioner_if;
  logic joy1up, joy1down, joy1left, joy1right, joy1fire1, joy1fire2;
  logic joy2up, joy2down, joy2left, joy2right, joy2fire1, joy2fire2;
  logic autofire1_en, autofire2_en;
  logic joy1up_o, joy1down_o, joy1left_o, joy1right_o, joy1fire1_o, joy1fire2_o;
  logic joy2up_o, joy2down_o, joy2left_o, joy2right_o, joy2fire1_o, joy2fire2_o;

  modport master (
    output joy1up, joy1down, joy1left, joy1right, joy1fire1, joy1fire2,
    output joy2up, joy2down, joy2left, joy2right, joy2fire1, joy2fire2,
    output autofire1_en, autofire2_en,
    input  joy1up_o, joy1down_o, joy1left_o, joy1right_o, joy1fire1_o, joy1fire2_o,
    input  joy2up_o, joy2down_o, joy2left_o, joy2right_o, joy2fire1_o, joy2fire2_o
  );

  modport slave (
    input  joy1up, joy1down, joy1left, joy1right, joy1fire1, joy1fire2,
    input  joy2up, joy2down, joy2left, joy2right, joy2fire1, joy2fire2,
    input  autofire1_en, autofire2_en,
    output joy1up_o, joy1down_o, joy1left_o, joy1right_o, joy1fire1_o, joy1fire2_o,
    output joy2up_o, joy2down_o, joy2left_o, joy2right_o, joy2fire1_o, joy2fire2_o
  );
endinterface

// File: rtl/joy_conditioner.sv
// joy_conditioner: conditions the two raw joysticks before the zxuno core.
// Pipeline: 2-flop input sync -> per-line debounce on a 1 ms tick ->
// per-joystick fire1 autofire -> optional SOCD cleaning -> output register.
// Line index inside each joystick: 0 up, 1 down, 2 left, 3 right, 4 fire1,
// 5 fire2; joystick 2 occupies indices 6..11. All lines are active-low.
// Optional feature: define JOY_SOCD_CLEAN_EN to release both lines of an
// opposite-direction pair (up/down, left/right) when both are pressed.
module joy_conditioner #(
  parameter int MASTERCLK        = 28000000,
  parameter int DEBOUNCE_MS      = 4,
  parameter int AUTOFIRE_HALF_MS = 40
) (
  input logic              sysclk,
  input logic              rst_n,
  joy_conditioner_if.slave joy
);

  localparam int TICK_DIV = MASTERCLK / 1000;
  localparam int TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [3:0]        DB_LAST   = 4'(DEBOUNCE_MS - 1);
  localparam logic [7:0]        HALF_LAST = 8'(AUTOFIRE_HALF_MS - 1);
  localparam int FIRE1 = 4;
  localparam int JOY_W = 6;

  typedef enum logic [1:0] {AF_IDLE, AF_SHOT, AF_GAP} af_state_e;

  logic [11:0]       raw;
  logic [11:0]       sync1_q, sync2_q;
  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic              tick;
  logic [11:0]       db_q, db_d;
  logic [3:0]        dc_q [12];
  logic [3:0]        dc_d [12];
  af_state_e         af_state_q [2];
  af_state_e         af_state_d [2];
  logic [7:0]        af_phase_q [2];
  logic [7:0]        af_phase_d [2];
  logic [1:0]        af_en, af_fire_db, af_fire;
  logic [11:0]       cond, out_d, out_q;

  assign raw = {joy.joy2fire2, joy.joy2fire1, joy.joy2right, joy.joy2left, joy.joy2down, joy.joy2up,
                joy.joy1fire2, joy.joy1fire1, joy.joy1right, joy.joy1left, joy.joy1down, joy.joy1up};

  // Double-register the asynchronous joystick lines into sysclk.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end

  // 1 ms prescaler: tick is high while the counter holds its terminal value.
  assign tick       = (tick_cnt_q == TICK_LAST);
  assign tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;

  // Tick counter register.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) tick_cnt_q <= '0;
    else        tick_cnt_q <= tick_cnt_d;
  end

  // Debounce next state: a new level must differ on DEBOUNCE_MS consecutive ticks.
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    db_d = db_q;
    for (int i = 0; i < 12; i++) begin
      dc_d[i] = dc_q[i];
      if (tick) begin
        if (sync2_q[i] == db_q[i]) begin
          dc_d[i] = '0;
        end else if (dc_q[i] == DB_LAST) begin
          db_d[i] = sync2_q[i];
          dc_d[i] = '0;
        end else begin
          dc_d[i] = dc_q[i] + 4'd1;
        end
      end
    end
  end

  // Debounce state registers.
  // NOTE: the count array is reset too; a half-finished debounce must not survive reset.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      db_q <= '1;
      for (int i = 0; i < 12; i++) dc_q[i] <= '0;
    end else begin
      db_q <= db_d;
      for (int i = 0; i < 12; i++) dc_q[i] <= dc_d[i];
    end
  end

  assign af_en      = {joy.autofire2_en, joy.autofire1_en};
  assign af_fire_db = {db_q[JOY_W + FIRE1], db_q[FIRE1]};

  // Autofire FSMs: next state, phase counter and fire1 value per joystick.
  // Leaving SHOT/GAP passes debounced fire1 straight through in the same cycle.
  always_comb begin
    for (int j = 0; j < 2; j++) begin
      af_state_d[j] = af_state_q[j];
      af_phase_d[j] = af_phase_q[j];
      af_fire[j]    = af_fire_db[j];
      case (af_state_q[j])
        AF_IDLE: begin
          if (!af_fire_db[j] && af_en[j]) begin
            af_state_d[j] = AF_SHOT;
            af_phase_d[j] = '0;
          end
        end
        AF_SHOT, AF_GAP: begin
          if (af_fire_db[j] || !af_en[j]) begin
            af_state_d[j] = AF_IDLE;
            af_phase_d[j] = '0;
          end else begin
            af_fire[j] = (af_state_q[j] == AF_GAP);
            if (tick) begin
              if (af_phase_q[j] == HALF_LAST) begin
                af_state_d[j] = (af_state_q[j] == AF_SHOT) ? AF_GAP : AF_SHOT;
                af_phase_d[j] = '0;
              end else begin
                af_phase_d[j] = af_phase_q[j] + 8'd1;
              end
            end
          end
        end
        default: begin
          af_state_d[j] = AF_IDLE;
          af_phase_d[j] = '0;
        end
      endcase
    end
  end

  // Autofire state and phase registers.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < 2; j++) begin
        af_state_q[j] <= AF_IDLE;
        af_phase_q[j] <= '0;
      end
    end else begin
      for (int j = 0; j < 2; j++) begin
        af_state_q[j] <= af_state_d[j];
        af_phase_q[j] <= af_phase_d[j];
      end
    end
  end

  // Merge autofire fire1 into the debounced lines; fire2 is never touched.
  always_comb begin
    cond                = db_q;
    cond[FIRE1]         = af_fire[0];
    cond[JOY_W + FIRE1] = af_fire[1];
  end

  // Optional SOCD cleaning ahead of the output register.
  always_comb begin
    out_d = cond;
`ifdef JOY_SOCD_CLEAN_EN
    for (int j = 0; j < 2; j++) begin
      if (!cond[j*JOY_W + 0] && !cond[j*JOY_W + 1]) begin
        out_d[j*JOY_W + 0] = 1'b1;
        out_d[j*JOY_W + 1] = 1'b1;
      end
      if (!cond[j*JOY_W + 2] && !cond[j*JOY_W + 3]) begin
        out_d[j*JOY_W + 2] = 1'b1;
        out_d[j*JOY_W + 3] = 1'b1;
      end
    end
`endif
  end

  // Output register, released (all ones) in reset.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) out_q <= '1;
    else        out_q <= out_d;
  end

  assign joy.joy1up_o    = out_q[0];
  assign joy.joy1down_o  = out_q[1];
  assign joy.joy1left_o  = out_q[2];
  assign joy.joy1right_o = out_q[3];
  assign joy.joy1fire1_o = out_q[4];
  assign joy.joy1fire2_o = out_q[5];
  assign joy.joy2up_o    = out_q[6];
  assign joy.joy2down_o  = out_q[7];
  assign joy.joy2left_o  = out_q[8];
  assign joy.joy2right_o = out_q[9];
  assign joy.joy2fire1_o = out_q[10];
  assign joy.joy2fire2_o = out_q[11];

endmodule

// File: tb/tb_joy_conditioner.sv
// Directed testbench for joy_conditioner (MASTERCLK=10000 -> tick every 10
// cycles, DEBOUNCE_MS=4, AUTOFIRE_HALF_MS=3). Each scenario starts from a
// reset so tick alignment is known: after reset release, the counter holds
// k mod 10 after posedge k, so debounce updates land on posedges 10,20,30...
// Outputs are sampled on the falling edge; "edge n" is the n-th rising edge
// after reset release. Expectations depend on JOY_SOCD_CLEAN_EN where noted.
module tb_joy_conditioner;

  logic        sysclk = 1'b0;
  logic        rst_n  = 1'b0;
  logic [11:0] raw    = 12'hFFF;
  logic        en1    = 1'b0;
  logic        en2    = 1'b0;
  logic [11:0] outs;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          edge_n   = 0;
  logic        seen_low;

  always #5 sysclk = ~sysclk;

  joy_conditioner_if jif ();

  assign jif.joy1up    = raw[0];
  assign jif.joy1down  = raw[1];
  assign jif.joy1left  = raw[2];
  assign jif.joy1right = raw[3];
  assign jif.joy1fire1 = raw[4];
  assign jif.joy1fire2 = raw[5];
  assign jif.joy2up    = raw[6];
  assign jif.joy2down  = raw[7];
  assign jif.joy2left  = raw[8];
  assign jif.joy2right = raw[9];
  assign jif.joy2fire1 = raw[10];
  assign jif.joy2fire2 = raw[11];
  assign jif.autofire1_en = en1;
  assign jif.autofire2_en = en2;

  assign outs = {jif.joy2fire2_o, jif.joy2fire1_o, jif.joy2right_o, jif.joy2left_o,
                 jif.joy2down_o, jif.joy2up_o, jif.joy1fire2_o, jif.joy1fire1_o,
                 jif.joy1right_o, jif.joy1left_o, jif.joy1down_o, jif.joy1up_o};

  joy_conditioner #(
    .MASTERCLK        (10000),
    .DEBOUNCE_MS      (4),
    .AUTOFIRE_HALF_MS (3)
  ) dut (
    .sysclk (sysclk),
    .rst_n  (rst_n),
    .joy    (jif.slave)
  );

  task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%03h, expected 0x%03h (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  // Advance to the falling edge that follows rising edge e.
  task automatic run_to(input int e);
    while (edge_n < e) begin
      @(negedge sysclk);
      edge_n++;
    end
  endtask

  // Called on a falling edge; releases reset on a falling edge (edge 0).
  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge sysclk);
    rst_n  = 1'b1;
    edge_n = 0;
  endtask

  logic [11:0] exp_all_pressed;
  logic        exp_lr_both;

  initial begin
`ifdef JOY_SOCD_CLEAN_EN
    exp_all_pressed = 12'h3CF;
    exp_lr_both     = 1'b1;
`else
    exp_all_pressed = 12'h000;
    exp_lr_both     = 1'b0;
`endif

    // 1. Reset with every input pressed.
    raw = 12'h000;
    @(negedge sysclk);
    #1;
    check("reset_outputs_released", outs, 12'hFFF);
    do_reset();
    run_to(40);
    check("reset_release_before_debounce", outs, 12'hFFF);
    run_to(41);
    check("reset_release_after_debounce", outs, exp_all_pressed);

    // 2. Glitch rejection, then a clean 60-cycle press.
    raw = 12'hFFF;
    do_reset();
    raw[0]   = 1'b0;
    seen_low = 1'b0;
    for (int e = 1; e <= 60; e++) begin
      run_to(e);
      if (e == 25) raw[0] = 1'b1;
      if (outs[0] == 1'b0) seen_low = 1'b1;
    end
    check("glitch_rejected", {11'd0, seen_low}, 12'd0);
    raw[0] = 1'b0;
    run_to(100);
    check("press_not_yet_accepted", {11'd0, outs[0]}, 12'd1);
    run_to(101);
    check("press_accepted_41_cycles", {11'd0, outs[0]}, 12'd0);
    run_to(120);
    raw[0] = 1'b1;
    run_to(160);
    check("release_not_yet_accepted", {11'd0, outs[0]}, 12'd0);
    run_to(161);
    check("release_accepted", {11'd0, outs[0]}, 12'd1);

    // 3. Autofire on joystick 1, joystick 2 fire1 held without autofire.
    raw = 12'hFFF;
    do_reset();
    en1 = 1'b1;
    en2 = 1'b0;
    raw[4]  = 1'b0;
    raw[10] = 1'b0;
    run_to(40);
    check("af_before_db", {11'd0, outs[4]}, 12'd1);
    run_to(41);
    check("af_first_shot_start", {11'd0, outs[4]}, 12'd0);
    check("af2_steady_pressed_a", {11'd0, outs[10]}, 12'd0);
    run_to(70);
    check("af_first_shot_end", {11'd0, outs[4]}, 12'd0);
    run_to(71);
    check("af_gap_start", {11'd0, outs[4]}, 12'd1);
    check("af2_steady_pressed_b", {11'd0, outs[10]}, 12'd0);
    run_to(100);
    check("af_gap_end", {11'd0, outs[4]}, 12'd1);
    run_to(101);
    check("af_second_shot", {11'd0, outs[4]}, 12'd0);
    check("af_fire2_untouched", {11'd0, outs[5]}, 12'd1);
    run_to(130);
    check("af_second_shot_end", {11'd0, outs[4]}, 12'd0);
    run_to(131);
    check("af_second_gap", {11'd0, outs[4]}, 12'd1);

    // 4. Exit: drop enable mid-GAP, then release fire1 mid-SHOT.
    run_to(145);
    check("af_mid_gap", {11'd0, outs[4]}, 12'd1);
    en1 = 1'b0;
    run_to(146);
    check("af_en_drop_pressed", {11'd0, outs[4]}, 12'd0);
    run_to(170);
    check("af_disabled_steady", {11'd0, outs[4]}, 12'd0);
    en1 = 1'b1;
    run_to(171);
    check("af_reenable_shot", {11'd0, outs[4]}, 12'd0);
    run_to(200);
    check("af_reenable_shot_end", {11'd0, outs[4]}, 12'd0);
    run_to(201);
    check("af_reenable_gap", {11'd0, outs[4]}, 12'd1);
    run_to(207);
    raw[4] = 1'b1;
    run_to(231);
    check("af_shot_before_release", {11'd0, outs[4]}, 12'd0);
    run_to(240);
    check("af_shot_at_db_release", {11'd0, outs[4]}, 12'd0);
    run_to(241);
    check("af_release_exit", {11'd0, outs[4]}, 12'd1);
    en1 = 1'b0;

    // 5. SOCD on joystick 2 left/right.
    raw = 12'hFFF;
    do_reset();
    raw[8] = 1'b0;
    raw[9] = 1'b0;
    run_to(41);
    check("socd_left_both", {11'd0, outs[8]}, {11'd0, exp_lr_both});
    check("socd_right_both", {11'd0, outs[9]}, {11'd0, exp_lr_both});
    check("socd_others_idle", outs & 12'hCFF, 12'hCFF);
    run_to(50);
    raw[9] = 1'b1;
    run_to(90);
    check("socd_left_before_db", {11'd0, outs[8]}, {11'd0, exp_lr_both});
    run_to(91);
    check("socd_left_alone", {11'd0, outs[8]}, 12'd0);
    check("socd_right_released", {11'd0, outs[9]}, 12'd1);

    // 6. Reset in the middle of a burst.
    raw = 12'hFFF;
    do_reset();
    en1 = 1'b1;
    raw[4] = 1'b0;
    run_to(55);
    check("burst_before_reset", {11'd0, outs[4]}, 12'd0);
    rst_n = 1'b0;
    #1;
    check("burst_reset_immediate", outs, 12'hFFF);
    do_reset();
    run_to(40);
    check("burst_after_reset_idle", {11'd0, outs[4]}, 12'd1);
    run_to(41);
    check("burst_restart_shot", {11'd0, outs[4]}, 12'd0);
    run_to(70);
    check("burst_restart_full_shot", {11'd0, outs[4]}, 12'd0);
    run_to(71);
    check("burst_restart_gap", {11'd0, outs[4]}, 12'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
